simple_bus_arbiter: RTL and testbench

//  Round-robin arbiter sharing one simple_bus master (data/valid/ready) among
//  NUM_REQ requester streams. Grants one requester at a time, holds the grant
//  for a burst of up to MAX_BURST beats, then rotates priority. Sits between
//  per-source producers and the single bus master modport of a simple_bus.

---
 rtl/simple_bus_arbiter.sv | 82 ++++++++
 tb/tb_simple_bus_arbiter.sv | 114 +++++++++++
 2 files changed

// File: rtl/simple_bus_arbiter.sv
// simple_bus_arbiter: round-robin arbiter multiplexing NUM_REQ valid/ready streams onto one bus, bursts of up to MAX_BURST beats
module simple_bus_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [DATA_W-1:0]         bus_data,
   output logic                      bus_valid,
   input  logic                      bus_ready,
   output logic [NUM_REQ-1:0]        grant,
   output logic                      busy
);
   localparam int PW = $clog2(NUM_REQ);
   localparam int BW = $clog2(MAX_BURST + 1);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [PW-1:0]      gidx_q, gidx_d, rr_q, rr_d, idx, sel;
   logic [BW-1:0]      beat_q, beat_d;
   logic               found, beat;
   assign grant     = grant_q;
   assign busy      = state_q == GRANT;
   assign bus_valid = busy & req_valid[gidx_q];
   assign bus_data  = busy ? req_data[gidx_q*DATA_W +: DATA_W] : '0;
   assign req_ready = busy ? (grant_q & {NUM_REQ{bus_ready}}) : '0;
   assign beat      = bus_valid & bus_ready;
   // first requester at or after rr_q, wrapping
   always_comb begin
      found = 1'b0;
      sel   = '0;
      idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = PW'((int'(rr_q) + i) % NUM_REQ);
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gidx_d  = gidx_q;
      rr_d    = rr_q;
      beat_d  = beat_q;
      if (state_q == IDLE) begin
         if (found) begin
            state_d = GRANT;
            grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel;
            gidx_d  = sel;
            beat_d  = '0;
         end
      end else if (!req_valid[gidx_q] || (beat && beat_q == BW'(MAX_BURST - 1))) begin
         state_d = IDLE;
         grant_d = '0;
         beat_d  = '0;
         rr_d    = PW'((int'(gidx_q) + 1) % NUM_REQ);
      end else if (beat) begin
         beat_d = beat_q + 1'b1;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         rr_q    <= '0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         rr_q    <= rr_d;
         beat_q  <= beat_d;
      end
   end
endmodule

// File: tb/tb_simple_bus_arbiter.sv
// tb_simple_bus_arbiter: random valid-hold traffic checked against a burst-level round-robin model
module tb_simple_bus_arbiter;
   localparam int N  = 4;
   localparam int W  = 8;
   localparam int MB = 4;
   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   req_ready;
   logic [W-1:0]   bus_data;
   logic           bus_valid;
   logic           bus_ready;
   logic [N-1:0]   grant;
   logic           busy;
   logic [N-1:0]   v, hs;
   logic [W-1:0]   d [N];
   int             cur, nb, ptr;
   int             n_chk, n_pass;
   simple_bus_arbiter #(.NUM_REQ(N), .DATA_W(W), .MAX_BURST(MB)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .bus_data(bus_data), .bus_valid(bus_valid),
      .bus_ready(bus_ready), .grant(grant), .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
   endtask
   task automatic drive();
      req_valid = v;
      for (int i = 0; i < N; i++) req_data[i*W +: W] = d[i];
   endtask
   // called at a negedge; returns at the next negedge
   task automatic run_cycle(input int pv, input int pr, input logic [N-1:0] mask);
      logic [N-1:0] eg;
      int           j;
      for (int i = 0; i < N; i++)
         if (!v[i] || hs[i]) begin
            v[i] = mask[i] && ($urandom_range(99) < pv);
            d[i] = W'($urandom);
         end
      bus_ready = $urandom_range(99) < pr;
      drive();
      #1;
      eg = cur < 0 ? '0 : N'(1) << cur;
      check("grant", 32'(grant), 32'(eg));
      check("busy", 32'(busy), 32'(cur >= 0));
      check("bus_valid", 32'(bus_valid), 32'(cur >= 0 && v[cur]));
      check("bus_data", 32'(bus_data), cur >= 0 ? 32'(d[cur]) : 32'd0);
      check("req_ready", 32'(req_ready), bus_ready ? 32'(eg) : 32'd0);
      check("onehot0", 32'($onehot0(grant)), 32'd1);
      hs = (bus_ready ? eg : '0) & v;
      if (cur < 0) begin
         for (int k = 0; k < N; k++) begin
            j = (ptr + k) % N;
            if (cur < 0 && v[j]) begin
               cur = j;
               nb  = 0;
            end
         end
      end else if (!v[cur] || (bus_ready && nb == MB - 1)) begin
         ptr = (cur + 1) % N;
         cur = -1;
      end else if (bus_ready) begin
         nb++;
      end
      @(negedge clk);
   endtask
   task automatic phase(input int n, input int pv, input int pr, input logic [N-1:0] mask);
      for (int c = 0; c < n; c++) run_cycle(pv, pr, mask);
   endtask
   initial begin
      n_chk = 0; n_pass = 0;
      rst_n = 1'b0; bus_ready = 1'b0; v = '0; hs = '0;
      for (int i = 0; i < N; i++) d[i] = '0;
      drive();
      cur = -1; nb = 0; ptr = 0;
      repeat (2) @(negedge clk);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_bus_valid", 32'(bus_valid), 32'd0);
      check("rst_bus_data", 32'(bus_data), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      rst_n = 1'b1;
      phase(14, 100, 100, 4'b0100);
      phase(25, 100, 100, 4'b1111);
      phase(400, 60, 70, 4'b1111);
      phase(8, 100, 0, 4'b1111);
      phase(200, 30, 50, 4'b1111);
      phase(30, 0, 100, 4'b0000);
      phase(3, 100, 100, 4'b0100);
      check("pre_rst_busy", 32'(busy), 32'd1);
      check("pre_rst_grant", 32'(grant), 32'b0100);
      rst_n = 1'b0;
      #1;
      check("mid_rst_grant", 32'(grant), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_bus_valid", 32'(bus_valid), 32'd0);
      check("mid_rst_req_ready", 32'(req_ready), 32'd0);
      check("mid_rst_bus_data", 32'(bus_data), 32'd0);
      v = 4'b0101; hs = '0;
      drive();
      cur = -1; nb = 0; ptr = 0;
      @(negedge clk);
      rst_n = 1'b1;
      phase(2, 100, 100, 4'b0101);
      check("post_rst_grant", 32'(grant), 32'b0001);
      phase(300, 50, 60, 4'b1111);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
